// File: rtl/rxuart_pkg.sv
// rtl/rxuart_pkg.sv - shared types and widths for the rxuart receiver
package rxuart_pkg;

  localparam int BAUD_W    = 24;
  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_e;

endpackage

// File: rtl/rxuart_if.sv
// rtl/rxuart_if.sv - serial line and received-byte strobe bundle; o_parity_err only with RXUART_PARITY_EN
interface rxuart_if;
  import rxuart_pkg::*;

  logic              i_uart_rx;
  logic              o_wr;
  logic [DATA_W-1:0] o_data;
  logic              o_frame_err;
`ifdef RXUART_PARITY_EN
  logic              o_parity_err;

  modport slave  (input  i_uart_rx, output o_wr, output o_data, output o_frame_err, output o_parity_err);
  modport master (output i_uart_rx, input  o_wr, input  o_data, input  o_frame_err, input  o_parity_err);
`else
  modport slave  (input  i_uart_rx, output o_wr, output o_data, output o_frame_err);
  modport master (output i_uart_rx, input  o_wr, input  o_data, input  o_frame_err);
`endif

endinterface

// File: rtl/rxuart_ff_sync.sv
// rtl/rxuart_ff_sync.sv - multi-flop synchronizer with configurable reset value
module ff_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/rxuart.sv
// rtl/rxuart.sv - 8N1 UART receiver with mid-baud sampling; RXUART_PARITY_EN adds an even-parity bit
module rxuart
  import rxuart_pkg::*;
#(
  parameter logic [BAUD_W-1:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  rxuart_if.slave bus
);

  localparam logic [BAUD_W-1:0] HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - BAUD_W'(1);
  localparam logic [BAUD_W-1:0] FULL_LOAD = CLOCKS_PER_BAUD - BAUD_W'(1);

  logic rx_s;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  frame_err_q, frame_err_d;
`ifdef RXUART_PARITY_EN
  logic                  parity_q, parity_d;
  logic                  parity_err_q, parity_err_d;
`endif

  logic sampling;
  logic tick;

  ff_sync #(
    .STAGES    (2),
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (bus.i_uart_rx),
    .o_q       (rx_s)
  );

  assign sampling = (state_q == START) || (state_q == DATA) ||
                    (state_q == PARITY) || (state_q == STOP);
  assign tick     = sampling && (baud_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    frame_err_d = frame_err_q;
`ifdef RXUART_PARITY_EN
    parity_d     = parity_q;
    parity_err_d = parity_err_q;
`endif

    if (sampling) begin
      baud_cnt_d = tick ? FULL_LOAD : (baud_cnt_q - BAUD_W'(1));
    end

    case (state_q)
      IDLE: begin
        // Half-baud load puts every later tick at the bit centre
        if (!rx_s) begin
          baud_cnt_d = HALF_LOAD;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {rx_s, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
`ifdef RXUART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RXUART_PARITY_EN
      PARITY: begin
        if (tick) begin
          parity_d = rx_s;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          wr_d        = 1'b1;
          data_d      = shift_q;
          frame_err_d = !rx_s;
`ifdef RXUART_PARITY_EN
          parity_err_d = ^{shift_q, parity_q};
`endif
          // A low stop bit may be a break; hold off until the line recovers
          state_d = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef RXUART_PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
`ifdef RXUART_PARITY_EN
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.o_wr        = wr_q;
  assign bus.o_data      = data_q;
  assign bus.o_frame_err = frame_err_q;
`ifdef RXUART_PARITY_EN
  assign bus.o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_rxuart.sv
// tb/tb_rxuart.sv - directed scoreboard bench for rxuart; RXUART_PARITY_EN enables the parity steps
module tb_rxuart;
  import rxuart_pkg::*;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wr_count = 0;
  int   wr_cyc = -1;
  int   stop_cyc = 0;
  logic prev_wr = 1'b0;
  exp_t sb[$];

  rxuart_if u_if();

  rxuart #(
    .CLOCKS_PER_BAUD (24'd16)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (u_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (u_if.o_wr === 1'b1) begin
      check("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
      wr_count++;
      wr_cyc = cyc;
      check("wr_expected", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("o_data", {24'd0, u_if.o_data}, {24'd0, e.data});
        check("o_frame_err", {31'd0, u_if.o_frame_err}, {31'd0, e.ferr});
`ifdef RXUART_PARITY_EN
        check("o_parity_err", {31'd0, u_if.o_parity_err}, {31'd0, e.perr});
`endif
      end
    end
    prev_wr = u_if.o_wr;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    u_if.i_uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    u_if.i_uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip_par);
    exp_t e;
    e.data = b;
    e.ferr = !stop_bit;
    e.perr = flip_par;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RXUART_PARITY_EN
    drive_bit((^b) ^ flip_par);
`endif
    stop_cyc = cyc;
    drive_bit(stop_bit);
  endtask

  initial begin
    int   base;
    logic [7:0] hello [5];
    logic [7:0] aborted;
    hello   = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    aborted = 8'h3C;

    rst_n          = 1'b0;
    u_if.i_uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_o_wr", {31'd0, u_if.o_wr}, 32'd0);
    check("reset_o_data", {24'd0, u_if.o_data}, 32'd0);
    check("reset_o_frame_err", {31'd0, u_if.o_frame_err}, 32'd0);
    rst_n = 1'b1;
    idle(10);

    // 1: single byte and stop-midpoint-to-strobe latency
    base = wr_count;
    send_frame(8'h48, 1'b1, 1'b0);
    idle(20);
    check("t1_wr_count", wr_count - base, 32'd1);
    check("t1_latency", wr_cyc, stop_cyc + 11);
    check("t1_sb_empty", sb.size(), 32'd0);

    // 2: back-to-back frames with no idle gap
    base = wr_count;
    for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1, 1'b0);
    idle(20);
    check("t2_wr_count", wr_count - base, 32'd5);
    check("t2_sb_empty", sb.size(), 32'd0);

    // 3: short glitch is rejected, next frame still received
    base = wr_count;
    u_if.i_uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(3 * CPB);
    check("t3_glitch_no_wr", wr_count - base, 32'd0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    check("t3_wr_count", wr_count - base, 32'd1);

    // 4: framing error followed by a held break, then recovery
    base = wr_count;
    send_frame(8'hA5, 1'b0, 1'b0);
    u_if.i_uart_rx = 1'b0;
    repeat (5 * CPB) @(posedge clk);
    #1;
    idle(2 * CPB);
    check("t4_break_one_wr", wr_count - base, 32'd1);
    send_frame(8'h21, 1'b1, 1'b0);
    idle(20);
    check("t4_wr_count", wr_count - base, 32'd2);
    check("t4_sb_empty", sb.size(), 32'd0);

    // 5: reset in the middle of data bit 4, held until the line is idle
    base = wr_count;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(aborted[i]);
    u_if.i_uart_rx = aborted[4];
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_reset_o_wr", {31'd0, u_if.o_wr}, 32'd0);
    check("t5_reset_o_data", {24'd0, u_if.o_data}, 32'd0);
    check("t5_reset_o_frame_err", {31'd0, u_if.o_frame_err}, 32'd0);
    repeat (CPB - 8) @(posedge clk);
    #1;
    for (int i = 5; i < 8; i++) drive_bit(aborted[i]);
    drive_bit(1'b1);
    rst_n = 1'b1;
    idle(2 * CPB);
    check("t5_aborted_no_wr", wr_count - base, 32'd0);
    send_frame(8'h0D, 1'b1, 1'b0);
    idle(20);
    check("t5_wr_count", wr_count - base, 32'd1);

`ifdef RXUART_PARITY_EN
    // 6: good and corrupted parity
    base = wr_count;
    send_frame(8'h48, 1'b1, 1'b0);
    send_frame(8'h48, 1'b1, 1'b1);
    idle(20);
    check("t6_wr_count", wr_count - base, 32'd2);
`endif

    check("final_sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
